// File: rtl/cache_flush_ctrl.sv
// Cache flush controller: walks every set/way, writes back dirty lines and clears their dirty bits.
// Optional clean-set skipping is enabled by defining CACHE_FLUSH_SKIP_CLEAN_SET_EN.
module cache_flush_ctrl #(
   parameter int NUMWAYS  = 4,
   parameter int NUMLINES = 128,
   parameter int SETLEN   = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                FlushReq,
   input  logic                FlushStage,
   input  logic [NUMWAYS-1:0]  ValidWay,
   input  logic [NUMWAYS-1:0]  DirtyWay,
   input  logic                BusAck,
   output logic [SETLEN-1:0]   FlushAdr,
   output logic [NUMWAYS-1:0]  FlushWay,
   output logic                CacheEn,
   output logic                WBReq,
   output logic                ClearDirty,
   output logic                FlushBusy,
   output logic                FlushDone
);

   localparam int WAYLEN = $clog2(NUMWAYS);
   localparam logic [WAYLEN-1:0] LAST_WAY = WAYLEN'(NUMWAYS - 1);
   localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_WRITEBACK,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SETLEN-1:0]   r_set;
   logic [WAYLEN-1:0]   r_way;
   logic                r_abort;
   logic [NUMWAYS-1:0]  w_way_oh;
   logic                w_skip;
   logic                w_adv;
   logic                w_way_inc;
   logic                w_set_inc;
   logic                w_cnt_clr;

   assign w_way_oh = {{(NUMWAYS-1){1'b0}}, 1'b1} << r_way;

`ifdef CACHE_FLUSH_SKIP_CLEAN_SET_EN
   // A set with no valid+dirty way seen at way 0 has nothing left to write back.
   assign w_skip = (r_state == S_CHECK) && (r_way == '0) && ((ValidWay & DirtyWay) == '0);
`else
   assign w_skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_adv     = 1'b0;
      w_way_inc = 1'b0;
      w_set_inc = 1'b0;
      w_cnt_clr = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (FlushReq) begin
               w_next    = S_READ;
               w_cnt_clr = 1'b1;
            end
         end
         S_READ: begin
            if (FlushStage) begin
               w_next    = S_IDLE;
               w_cnt_clr = 1'b1;
            end else begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (FlushStage) begin
               w_next    = S_IDLE;
               w_cnt_clr = 1'b1;
            end else if ((ValidWay & DirtyWay & w_way_oh) != '0) begin
               w_next = S_WRITEBACK;
            end else begin
               w_adv = 1'b1;
            end
         end
         S_WRITEBACK: begin
            if (BusAck) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            if (r_abort) begin
               w_next    = S_IDLE;
               w_cnt_clr = 1'b1;
            end else begin
               w_adv = 1'b1;
            end
         end
         S_DONE: begin
            w_next    = S_IDLE;
            w_cnt_clr = 1'b1;
         end
         default: begin
            w_next    = S_IDLE;
            w_cnt_clr = 1'b1;
         end
      endcase

      if (w_adv) begin
         if ((r_way != LAST_WAY) && !w_skip) begin
            w_next    = S_READ;
            w_way_inc = 1'b1;
         end else if (r_set != LAST_SET) begin
            w_next    = S_READ;
            w_set_inc = 1'b1;
         end else begin
            w_next = S_DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_set <= '0;
         r_way <= '0;
      end else if (w_cnt_clr) begin
         r_set <= '0;
         r_way <= '0;
      end else if (w_set_inc) begin
         r_set <= r_set + 1'b1;
         r_way <= '0;
      end else if (w_way_inc) begin
         r_way <= r_way + 1'b1;
      end
   end

   // An abort seen during the bus handshake is held until CLEAR finishes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                       r_abort <= 1'b0;
      else if ((r_state == S_WRITEBACK) && FlushStage) r_abort <= 1'b1;
      else if (w_next == S_IDLE)                       r_abort <= 1'b0;
   end

   always_comb begin
      FlushAdr   = r_set;
      FlushWay   = (r_state == S_IDLE) ? '0 : w_way_oh;
      CacheEn    = (r_state == S_READ);
      WBReq      = (r_state == S_WRITEBACK);
      ClearDirty = (r_state == S_CLEAR);
      FlushBusy  = (r_state != S_IDLE);
      FlushDone  = (r_state == S_DONE);
   end

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed self-checking bench for cache_flush_ctrl; cache contents come from a small valid/dirty array.
module tb_cache_flush_ctrl;

   logic       clk = 1'b0;
   logic       reset, FlushReq, FlushStage, BusAck;
   logic [3:0] ValidWay, DirtyWay;
   logic [6:0] FlushAdr;
   logic [3:0] FlushWay;
   logic       CacheEn, WBReq, ClearDirty, FlushBusy, FlushDone;

   logic [3:0] mem_v [128];
   logic [3:0] mem_d [128];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

`ifdef CACHE_FLUSH_SKIP_CLEAN_SET_EN
   localparam int EXP_DONE = 257, EXP_CEN = 128, EXP_WB_S5W2 = 17, EXP_WB_S3W1 = 11, EXP_WB_S7W0 = 17;
`else
   localparam int EXP_DONE = 1025, EXP_CEN = 512, EXP_WB_S5W2 = 47, EXP_WB_S3W1 = 29, EXP_WB_S7W0 = 59;
`endif

   always #5 clk = ~clk;

   assign ValidWay = mem_v[FlushAdr];
   assign DirtyWay = mem_d[FlushAdr];

   cache_flush_ctrl #(.NUMWAYS(4), .NUMLINES(128), .SETLEN(7)) dut (
      .clk(clk), .reset(reset), .FlushReq(FlushReq), .FlushStage(FlushStage),
      .ValidWay(ValidWay), .DirtyWay(DirtyWay), .BusAck(BusAck),
      .FlushAdr(FlushAdr), .FlushWay(FlushWay), .CacheEn(CacheEn), .WBReq(WBReq),
      .ClearDirty(ClearDirty), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) begin
         mem_v[i] = '0;
         mem_d[i] = '0;
      end
   endtask

   task automatic start_flush();
      FlushReq = 1'b1;
      step();
      FlushReq = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_wb(output int at);
      at = 0;
      for (int k = 0; k < 1200 && at == 0; k++) begin
         if (WBReq) at = cyc;
         else       step();
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_cen, n_wb, n_idle, n_clr, done_at, wb_at, found, n_done;
      reset = 1'b1; FlushReq = 1'b0; FlushStage = 1'b0; BusAck = 1'b0;
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", FlushBusy, 0);
      chk("rst_wbreq", WBReq, 0);
      chk("rst_adr", FlushAdr, 0);
      chk("rst_way", FlushWay, 0);
      chk("rst_cen", CacheEn, 0);
      chk("rst_done", FlushDone, 0);
      chk("rst_clr", ClearDirty, 0);

      // All clean: first request right after reset release
      reset = 1'b0;
      start_flush();
      chk("first_cen", CacheEn, 1);
      chk("first_busy", FlushBusy, 1);
      chk("first_adr", FlushAdr, 0);
      chk("first_way", FlushWay, 1);
      n_cen = 0; n_wb = 0; n_idle = 0; n_clr = 0; done_at = 0;
      while (done_at == 0 && cyc < 1200) begin
         if (CacheEn)    n_cen++;
         if (WBReq)      n_wb++;
         if (ClearDirty) n_clr++;
         if (!FlushBusy) n_idle++;
         if (FlushDone)  done_at = cyc;
         FlushReq = (cyc == 10 || cyc == 11);
         if (done_at == 0) step();
      end
      FlushReq = 1'b0;
      chk("clean_done_cycle", done_at, EXP_DONE);
      chk("clean_cen_count", n_cen, EXP_CEN);
      chk("clean_wb_count", n_wb, 0);
      chk("clean_clr_count", n_clr, 0);
      chk("clean_busy_low", n_idle, 0);
      step();
      chk("after_done_busy", FlushBusy, 0);
      chk("after_done_pulse", FlushDone, 0);
      repeat (3) step();
      chk("no_queued_busy", FlushBusy, 0);
      chk("no_queued_cen", CacheEn, 0);

      // Set 5 way 2 dirty, ack in the third write-back cycle
      mem_v[5] = 4'b1100; mem_d[5] = 4'b0100;
      mem_v[2] = 4'b1100; mem_d[2] = 4'b0011;
      start_flush();
      wait_wb(wb_at);
      chk("s5_wb_cycle", wb_at, EXP_WB_S5W2);
      chk("s5_wb_adr", FlushAdr, 5);
      chk("s5_wb_way", FlushWay, 4'b0100);
      n_wb = 0;
      for (int k = 0; k < 3; k++) begin
         if (WBReq && FlushAdr == 7'd5 && FlushWay == 4'b0100) n_wb++;
         if (k == 2) BusAck = 1'b1;
         step();
      end
      BusAck = 1'b0;
      chk("s5_wb_len", n_wb, 3);
      chk("s5_wb_drop", WBReq, 0);
      chk("s5_clr", ClearDirty, 1);
      step();
      chk("s5_clr_once", ClearDirty, 0);
      chk("s5_next_cen", CacheEn, 1);
      chk("s5_next_adr", FlushAdr, 5);
      chk("s5_next_way", FlushWay, 4'b1000);
      FlushStage = 1'b1;
      step();
      FlushStage = 1'b0;
      chk("abort_read_busy", FlushBusy, 0);
      chk("abort_read_done", FlushDone, 0);
      chk("abort_read_way", FlushWay, 0);

      // Abort during CHECK of set 10
      clear_mem();
      start_flush();
      found = 0;
      for (int k = 0; k < 1200 && found == 0; k++) begin
         if (CacheEn && FlushAdr == 7'd10) found = 1;
         else                              step();
      end
      chk("s10_reached", found, 1);
      step();
      chk("s10_check_busy", FlushBusy, 1);
      FlushStage = 1'b1;
      step();
      FlushStage = 1'b0;
      chk("abort_chk_busy", FlushBusy, 0);
      chk("abort_chk_adr", FlushAdr, 0);
      n_done = 0;
      for (int k = 0; k < 5; k++) begin
         if (FlushDone) n_done++;
         step();
      end
      chk("abort_chk_nodone", n_done, 0);

      // Abort latched during WRITEBACK of set 3 way 1, ack two cycles later
      mem_v[3] = 4'b0010; mem_d[3] = 4'b0010;
      start_flush();
      wait_wb(wb_at);
      chk("s3_wb_cycle", wb_at, EXP_WB_S3W1);
      n_wb = 1;
      FlushStage = 1'b1;
      step();
      FlushStage = 1'b0;
      if (WBReq) n_wb++;
      step();
      if (WBReq) n_wb++;
      BusAck = 1'b1;
      step();
      BusAck = 1'b0;
      chk("s3_wb_len", n_wb, 3);
      chk("s3_clr", ClearDirty, 1);
      chk("s3_clr_busy", FlushBusy, 1);
      step();
      chk("s3_idle_busy", FlushBusy, 0);
      chk("s3_idle_done", FlushDone, 0);
      chk("s3_idle_clr", ClearDirty, 0);

      // Reset in the middle of a write-back of set 7
      clear_mem();
      mem_v[7] = 4'b0001; mem_d[7] = 4'b0001;
      start_flush();
      wait_wb(wb_at);
      chk("s7_wb_cycle", wb_at, EXP_WB_S7W0);
      chk("s7_wb_adr", FlushAdr, 7);
      #3 reset = 1'b1;
      #1;
      chk("rst_wb_wbreq", WBReq, 0);
      chk("rst_wb_busy", FlushBusy, 0);
      chk("rst_wb_adr", FlushAdr, 0);
      chk("rst_wb_way", FlushWay, 0);
      clear_mem();
      @(posedge clk);
      #1;
      reset = 1'b0;
      start_flush();
      chk("restart_cen", CacheEn, 1);
      chk("restart_adr", FlushAdr, 0);
      chk("restart_way", FlushWay, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
